// File: rtl/scc_core_sequencer_if.sv
// Instruction and data memory handshake bundle at the SCC core boundary.
// The sequencer drives requests as master; the memory model/ports are the slave.
interface scc_core_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_mem;
  logic              in_mem_ready;
  logic [ADDR_W-1:0] in_mem_addr;
  logic              in_mem_en;
  logic [DATA_W-1:0] data_in;
  logic              data_ready;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_out;
  logic              data_read;
  logic              data_write;

  modport master (
    input  in_mem, in_mem_ready, data_in, data_ready,
    output in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write
  );

  modport slave (
    output in_mem, in_mem_ready, data_in, data_ready,
    input  in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write
  );
endinterface

// File: rtl/scc_core_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR, with
// wait-state tolerant memory handshakes and a per-access bus timeout.
module scc_core_sequencer #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4,
  parameter int                 TIMEOUT  = 255,
  parameter int                 CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  scc_core_sequencer_if.master   mem,
  output logic [DATA_W-1:0]      instruction,
  input  logic                   dec_halt,
  input  logic                   dec_load,
  input  logic                   dec_store,
  input  logic                   dec_wr_en,
  input  logic [ADDR_W-1:0]      exe_addr,
  input  logic [DATA_W-1:0]      exe_data,
  input  logic                   br_taken,
  input  logic [ADDR_W-1:0]      br_target,
  output logic                   reg_write_en,
  output logic [DATA_W-1:0]      load_data,
  output logic                   halted,
  output logic                   fault,
  output logic [CNT_W-1:0]       retired
);
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, br_target_q, br_target_d;
  logic [DATA_W-1:0] ir_q, ir_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              br_taken_q, br_taken_d, ld_q, ld_d, st_q, st_d, wr_q, wr_d;
  logic              in_mem_en_q, in_mem_en_d, data_read_q, data_read_d;
  logic              data_write_q, data_write_d, reg_write_en_q, reg_write_en_d;
  logic              halted_q, halted_d, fault_q, fault_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    ld_d        = ld_q;
    st_d        = st_q;
    wr_d        = wr_q;
    load_data_d = load_data_q;
    retired_d   = retired_q;
    wait_d      = wait_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem.in_mem_ready) begin
          ir_d    = mem.in_mem;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_W'(TIMEOUT)) state_d = S_FAULT;
        else wait_d = wait_q + 1'b1;
      end
      S_DECODE: state_d = dec_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        // Decode flags are captured here so MEM/WB outputs stay pure state decodes.
        addr_d      = exe_addr;
        wdata_d     = exe_data;
        br_taken_d  = br_taken;
        br_target_d = br_target;
        ld_d        = dec_load;
        st_d        = dec_store & ~dec_load;
        wr_d        = dec_wr_en;
        state_d     = (dec_load | dec_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem.data_ready) begin
          if (ld_q) load_data_d = mem.data_in;
          state_d = S_WB;
        end else if (wait_q == WAIT_W'(TIMEOUT)) state_d = S_FAULT;
        else wait_d = wait_q + 1'b1;
      end
      S_WB: begin
        pc_d      = br_taken_q ? br_target_q : pc_q + ADDR_W'(PC_STEP);
        retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = state_q;
    endcase
    if (state_d != state_q) wait_d = '0;

    in_mem_en_d    = (state_d == S_FETCH);
    data_read_d    = (state_d == S_MEM) && ld_d;
    data_write_d   = (state_d == S_MEM) && st_d;
    reg_write_en_d = (state_d == S_WB) && wr_d;
    halted_d       = (state_d == S_HALT);
    fault_d        = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      br_taken_q     <= 1'b0;
      br_target_q    <= '0;
      ld_q           <= 1'b0;
      st_q           <= 1'b0;
      wr_q           <= 1'b0;
      load_data_q    <= '0;
      retired_q      <= '0;
      wait_q         <= '0;
      in_mem_en_q    <= 1'b0;
      data_read_q    <= 1'b0;
      data_write_q   <= 1'b0;
      reg_write_en_q <= 1'b0;
      halted_q       <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      br_taken_q     <= br_taken_d;
      br_target_q    <= br_target_d;
      ld_q           <= ld_d;
      st_q           <= st_d;
      wr_q           <= wr_d;
      load_data_q    <= load_data_d;
      retired_q      <= retired_d;
      wait_q         <= wait_d;
      in_mem_en_q    <= in_mem_en_d;
      data_read_q    <= data_read_d;
      data_write_q   <= data_write_d;
      reg_write_en_q <= reg_write_en_d;
      halted_q       <= halted_d;
      fault_q        <= fault_d;
    end
  end

  assign mem.in_mem_addr = pc_q;
  assign mem.in_mem_en   = in_mem_en_q;
  assign mem.data_addr   = addr_q;
  assign mem.data_out    = wdata_q;
  assign mem.data_read   = data_read_q;
  assign mem.data_write  = data_write_q;
  assign instruction     = ir_q;
  assign reg_write_en    = reg_write_en_q;
  assign load_data       = load_data_q;
  assign halted          = halted_q;
  assign fault           = fault_q;
  assign retired         = retired_q;
endmodule

// File: tb/tb_scc_core_sequencer.sv
// Directed bench for scc_core_sequencer: main instance (RESET_PC=0x40,
// TIMEOUT=5) plus an 8-bit-address instance for PC wraparound.
module tb_scc_core_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  scc_core_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mem_a ();
  scc_core_sequencer_if #(.ADDR_W(8),  .DATA_W(32)) mem_b ();

  logic        dec_halt = 0, dec_load = 0, dec_store = 0, dec_wr_en = 0;
  logic [31:0] exe_addr = 0, exe_data = 0, br_target = 0;
  logic        br_taken = 0;
  logic [31:0] instruction, load_data;
  logic        reg_write_en, halted, fault;
  logic [15:0] retired;

  logic [31:0] instruction_b, load_data_b;
  logic        reg_write_en_b, halted_b, fault_b;
  logic [15:0] retired_b;

  scc_core_sequencer #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h40), .PC_STEP(4),
                       .TIMEOUT(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mem(mem_a), .instruction(instruction),
    .dec_halt(dec_halt), .dec_load(dec_load), .dec_store(dec_store), .dec_wr_en(dec_wr_en),
    .exe_addr(exe_addr), .exe_data(exe_data), .br_taken(br_taken), .br_target(br_target),
    .reg_write_en(reg_write_en), .load_data(load_data), .halted(halted), .fault(fault),
    .retired(retired));

  scc_core_sequencer #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'hFC), .PC_STEP(4),
                       .TIMEOUT(5), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .mem(mem_b), .instruction(instruction_b),
    .dec_halt(1'b0), .dec_load(1'b0), .dec_store(1'b0), .dec_wr_en(1'b1),
    .exe_addr(8'h0), .exe_data(32'h0), .br_taken(1'b0), .br_target(8'h0),
    .reg_write_en(reg_write_en_b), .load_data(load_data_b), .halted(halted_b),
    .fault(fault_b), .retired(retired_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
  endtask

  initial begin
    mem_a.in_mem = 0; mem_a.in_mem_ready = 1; mem_a.data_in = 0; mem_a.data_ready = 0;
    mem_b.in_mem = 32'h1; mem_b.in_mem_ready = 1; mem_b.data_in = 0; mem_b.data_ready = 0;
    #12;
    chk("rst_en", mem_a.in_mem_en, 0);
    chk("rst_pc", mem_a.in_mem_addr, 32'h40);
    chk("rst_ir", instruction, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_ret", retired, 0);
    chk("rst_flags", {halted, fault, reg_write_en, mem_a.data_read, mem_a.data_write}, 0);
    chk("rst_pc_b", mem_b.in_mem_addr, 8'hFC);

    // ALU instruction, zero-wait memory
    @(posedge clk); #1;
    reset = 0; mem_a.in_mem = 32'hA1; dec_wr_en = 1;
    step();
    chk("alu_c1_en", mem_a.in_mem_en, 1);
    chk("alu_c1_pc", mem_a.in_mem_addr, 32'h40);
    step();
    chk("alu_c2_ir", instruction, 32'hA1);
    chk("alu_c2_en", mem_a.in_mem_en, 0);
    step();
    chk("alu_c3_we", reg_write_en, 0);
    step();
    chk("alu_c4_we", reg_write_en, 1);
    step();
    chk("alu_c5_pc", mem_a.in_mem_addr, 32'h44);
    chk("alu_c5_en", mem_a.in_mem_en, 1);
    chk("alu_c5_ret", retired, 1);
    chk("alu_c5_we", reg_write_en, 0);
    chk("wrap_pc_b", mem_b.in_mem_addr, 8'h00);

    // Load with three wait states
    mem_a.in_mem = 32'hB2; dec_load = 1; exe_addr = 32'h1000; exe_data = 32'hDEAD;
    step(); step(); step();
    exe_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      chk("ld_rd", mem_a.data_read, 1);
      chk("ld_addr", mem_a.data_addr, 32'h1000);
      chk("ld_wr", mem_a.data_write, 0);
      if (i == 3) begin mem_a.data_ready = 1; mem_a.data_in = 32'hCAFEBABE; end
      step();
    end
    mem_a.data_ready = 0; mem_a.data_in = 32'h0;
    chk("ld_data", load_data, 32'hCAFEBABE);
    chk("ld_rd_off", mem_a.data_read, 0);
    chk("ld_we", reg_write_en, 1);
    step();
    chk("ld_pc", mem_a.in_mem_addr, 32'h48);
    chk("ld_ret", retired, 2);

    // Halt on third instruction
    dec_load = 0; dec_halt = 1; mem_a.in_mem = 32'hC3;
    step(); step();
    chk("halt_flag", halted, 1);
    for (int i = 0; i < 100; i++) begin
      chk("halt_en", mem_a.in_mem_en, 0);
      step();
    end
    chk("halt_ret", retired, 2);
    chk("halt_pc", mem_a.in_mem_addr, 32'h48);
    chk("halt_ir", instruction, 32'hC3);

    do_reset();
    chk("rst2_pc", mem_a.in_mem_addr, 32'h40);
    chk("rst2_halt", halted, 0);
    chk("rst2_ret", retired, 0);
    @(posedge clk); #1;
    reset = 0; dec_halt = 0; dec_wr_en = 0;
    br_taken = 1; br_target = 32'h100; mem_a.in_mem = 32'hD4;
    step();
    chk("rst2_fetch", mem_a.in_mem_en, 1);

    // Taken branch: no MEM, latched branch decision used in WB
    step(); step(); step();
    br_taken = 0; br_target = 32'h0;
    chk("br_nomem", {mem_a.data_read, mem_a.data_write}, 0);
    chk("br_we", reg_write_en, 0);
    step();
    chk("br_pc", mem_a.in_mem_addr, 32'h100);
    chk("br_ret", retired, 1);

    // Fetch timeout with spurious data_ready
    mem_a.in_mem_ready = 0; mem_a.data_ready = 1; mem_a.in_mem = 32'hEE;
    for (int i = 0; i < 6; i++) begin
      chk("to_en", mem_a.in_mem_en, 1);
      chk("to_nofault", fault, 0);
      step();
    end
    chk("to_fault", fault, 1);
    chk("to_en_off", mem_a.in_mem_en, 0);
    mem_a.in_mem_ready = 1; mem_a.data_ready = 0;
    step(); step(); step();
    chk("to_sticky", fault, 1);
    chk("to_ignore_en", mem_a.in_mem_en, 0);
    chk("to_ignore_ir", instruction, 32'hD4);

    // ALU then store interrupted by reset mid-MEM
    do_reset();
    @(posedge clk); #1;
    reset = 0; dec_wr_en = 1; mem_a.in_mem = 32'hF1;
    step(); step(); step(); step(); step();
    chk("st_pre_ret", retired, 1);
    dec_store = 1; dec_wr_en = 0; exe_addr = 32'h2000; exe_data = 32'h12345678;
    mem_a.in_mem = 32'hE5;
    step(); step(); step();
    chk("st_wr", mem_a.data_write, 1);
    chk("st_rd", mem_a.data_read, 0);
    chk("st_addr", mem_a.data_addr, 32'h2000);
    chk("st_data", mem_a.data_out, 32'h12345678);
    step();
    chk("st_hold", mem_a.data_write, 1);
    #2 reset = 1'b1;
    #1;
    chk("st_rst_wr", mem_a.data_write, 0);
    chk("st_rst_pc", mem_a.in_mem_addr, 32'h40);
    chk("st_rst_ret", retired, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scc_core_sequencer.md
# scc_core_sequencer

Parametrised multicycle control sequencer for the SCC core. It replaces the gated-clock `halt` scheme with an explicit FETCH/DECODE/EXEC/MEM/WB state machine. It owns the PC and the instruction register and runs ready/valid-style handshakes to instruction and data memory with wait states and a bus timeout. It sits between the memory ports at the core boundary and the decode, execute and register-file blocks, which keep running on the free-running clock.

## Interface
- `ADDR_W`, 32: PC and memory address width.
- `DATA_W`, 32: instruction and data word width.
- `RESET_PC`, 0: PC value loaded on reset.
- `PC_STEP`, 4: sequential PC increment.
- `TIMEOUT`, 255: maximum wait cycles on any memory handshake, ≥1.
- `CNT_W`, 16: retired-instruction counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state cleared immediately.
- `in_mem` in DATA_W: fetched instruction word.
- `in_mem_ready` in 1: instruction memory has valid data this cycle.
- `in_mem_addr` out ADDR_W: fetch address, equal to the PC.
- `in_mem_en` out 1: fetch request.
- `data_in` in DATA_W: load data.
- `data_ready` in 1: data memory has completed the access this cycle.
- `data_addr` out ADDR_W: load/store address.
- `data_out` out DATA_W: store data.
- `data_read` out 1: load request.
- `data_write` out 1: store request.
- `instruction` out DATA_W: IR, sent to decode.
- `dec_halt`, `dec_load`, `dec_store`, `dec_wr_en` in 1 each: decode flags for the IR.
- `exe_addr` in ADDR_W: effective address. `exe_data` in DATA_W: store data.
- `br_taken` in 1, `br_target` in ADDR_W: branch resolution from EXE.
- `reg_write_en` out 1: one-cycle register-file write strobe.
- `load_data` out DATA_W: captured load word, for the writeback mux.
- `halted`, `fault` out 1: sticky status flags.
- `retired` out CNT_W: saturating count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. Reset puts the block in IDLE.
- IDLE → FETCH on the first clock edge after reset deasserts.
- FETCH:
  - `in_mem_en`=1 and `in_mem_addr`=PC.
  - On an edge with `in_mem_ready`=1: IR ← `in_mem`, then go to DECODE.
- DECODE:
  - If `dec_halt`=1, go to HALT; the PC is not advanced.
  - Otherwise go to EXEC.
- EXEC:
  - Latch `exe_addr`, `exe_data`, `br_taken` and `br_target`.
  - Go to MEM if `dec_load` or `dec_store` is set, otherwise go to WB.
- MEM:
  - `data_read` is held at `dec_load` and `data_write` at `dec_store`; both are never 1 together (load wins).
  - `data_addr` and `data_out` are driven from the EXEC latches and stay stable until `data_ready`.
  - On an edge with `data_ready`=1: `load_data` ← `data_in` for loads, then go to WB.
- WB:
  - `reg_write_en` = `dec_wr_en` for this cycle only.
  - PC ← `br_target` if the latched `br_taken` is set, else PC + PC_STEP, modulo 2^ADDR_W.
  - `retired` increments, holding at 2^CNT_W−1.
  - Then go to FETCH.
- HALT: terminal; all requests stay 0 and `halted`=1. Only `reset` exits.
- Timeout:
  - A wait counter runs in FETCH and MEM and clears on every state change.
  - If it reaches TIMEOUT without the matching ready, go to FAULT: `fault`=1 and all requests are 0.
  - FAULT is terminal until reset.
- Ready inputs are ignored outside their own state; a spurious `data_ready` in FETCH has no effect.
- Reset values: PC=RESET_PC, IR=0, `load_data`=0, `retired`=0, `halted`=0, `fault`=0, all request and strobe outputs 0. A reset mid-access drops requests asynchronously.

## Timing
- Request outputs and `reg_write_en` are pure decodes of the registered state, so they have no combinational path from inputs. `data_addr` and `data_out` come from registers.
- With zero-wait memory (ready=1 in the first request cycle):
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- Each wait cycle adds 1 cycle to FETCH or MEM.
- `in_mem_addr` changes only on the WB→FETCH edge.
- FAULT is entered on the edge where the wait count equals TIMEOUT, i.e. after TIMEOUT+1 request cycles with no ready.

## Test plan
- Reset with RESET_PC=0x40, ALU instruction (`dec_wr_en`=1), ready always high → `in_mem_en` high in cycle 1, `reg_write_en` pulse in cycle 4, `in_mem_addr`=0x44 in cycle 5, `retired`=1.
- Load with `exe_addr`=0x1000 and `data_ready` delayed 3 cycles → `data_read` high for 4 cycles with `data_addr` stable at 0x1000; `load_data` = `data_in` from the ready cycle; `data_write` stays 0.
- Taken branch with `br_target`=0x100 → no MEM state; next `in_mem_addr`=0x100; with ADDR_W=8 and PC=0xFC untaken, next PC=0x00.
- `dec_halt` on the third instruction → `halted`=1 and `in_mem_en`=0 for 100 cycles with `retired`=2; reset then restores FETCH at RESET_PC.
- TIMEOUT=5 with `in_mem_ready` held 0 → `fault`=1 after 6 request cycles, `in_mem_en` drops, and a later ready is ignored.
- Reset asserted mid-MEM during a store → `data_write` goes to 0 before the next edge, PC=RESET_PC, and `retired` clears.
